// File: rtl/seven_seg_scanner_pkg.sv
`default_nettype none
//==============================================================================
// Module   : seven_seg_scanner_pkg
// Brief    : Shared FSM encoding and segment constants for the 7-segment scanner.
// Revision : 1.0 - initial release
//==============================================================================
package seven_seg_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-high {g,f,e,d,c,b,a} with every segment dark
    localparam logic [6:0] c_seg_off = 7'b000_0000;

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
//==============================================================================
// Module   : hex_to_seg7
// Brief    : Combinational hex nibble to active-high {g..a} segment decoder.
// Revision : 1.0 - initial release
//==============================================================================
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b000_0000;
        case (nibble)
            4'h0: seg = 7'b011_1111;
            4'h1: seg = 7'b000_0110;
            4'h2: seg = 7'b101_1011;
            4'h3: seg = 7'b100_1111;
            4'h4: seg = 7'b110_0110;
            4'h5: seg = 7'b110_1101;
            4'h6: seg = 7'b111_1101;
            4'h7: seg = 7'b000_0111;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b110_1111;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b111_1100;
            4'hC: seg = 7'b011_1001;
            4'hD: seg = 7'b101_1110;
            4'hE: seg = 7'b111_1001;
            4'hF: seg = 7'b111_0001;
            default: seg = 7'b000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
//==============================================================================
// Module   : seven_seg_scanner
// Brief    : Time-multiplexed multi-digit 7-segment driver with blank gap,
//            leading-zero suppression and registered pin outputs.
// Revision : 1.0 - initial release
//==============================================================================
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int AN_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scan_clk,
    input  logic                        en,
    input  logic [4*DIGITS-1:0]         value,
    input  logic [DIGITS-1:0]           dp,
    input  logic                        blank_lz,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic                        dp_o,
    output logic [$clog2(DIGITS)-1:0]   digit_idx
);

    localparam int                  c_idx_w      = $clog2(DIGITS);
    localparam logic [c_idx_w-1:0]  c_last_idx   = c_idx_w'(DIGITS - 1);
    localparam logic [7:0]          c_blank_load = 8'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0]   c_an_off     = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]          c_seg_pin_off = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                c_dp_pin_off = (SEG_ACT_LOW != 0);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic                r_scan_q;
    logic                w_rise;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_nxt;
    logic [c_idx_w-1:0]  w_idx_inc;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                w_load;
    logic [3:0]          r_nib;
    logic                r_dp;
    logic                r_lz;
    logic [3:0]          w_snap_nib;
    logic                w_snap_dp;
    logic                w_snap_lz;
    logic [DIGITS-1:0]   w_lz_vec;
    logic                w_zero_run;
    logic [6:0]          w_seg_hi;
    logic [DIGITS-1:0]   w_an_act;
    logic [6:0]          w_seg_act;
    logic                w_dp_act;

    // scan_clk is already a registered clk-domain signal, so one flop suffices
    assign w_rise    = scan_clk & ~r_scan_q;
    assign w_idx_inc = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_idx_nxt   = '0;
                        w_load      = 1'b1;
                        w_cnt_nxt   = c_blank_load;
                        w_state_nxt = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (w_rise) begin
                        w_idx_nxt = w_idx_inc;
                        w_load    = 1'b1;
                        w_cnt_nxt = c_blank_load;
                    end else if (r_cnt <= 8'd1) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (w_rise) begin
                        w_idx_nxt   = w_idx_inc;
                        w_load      = 1'b1;
                        w_cnt_nxt   = c_blank_load;
                        w_state_nxt = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Digit i is a leading zero when it and every more-significant nibble are 0
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_vec   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run  = w_zero_run & (value[4*i +: 4] == 4'h0);
            w_lz_vec[i] = blank_lz & (i != 0) & w_zero_run;
        end
    end

    assign w_snap_nib = w_load ? value[{w_idx_nxt, 2'b00} +: 4] : r_nib;
    assign w_snap_dp  = w_load ? dp[w_idx_nxt]                  : r_dp;
    assign w_snap_lz  = w_load ? w_lz_vec[w_idx_nxt]            : r_lz;

    hex_to_seg7 u_dec (
        .nibble (w_snap_nib),
        .seg    (w_seg_hi)
    );

    // Pin values are derived from the next state so they register on the same edge
    always_comb begin
        w_an_act  = '0;
        w_seg_act = c_seg_off;
        w_dp_act  = 1'b0;
        if (w_state_nxt == ST_SHOW) begin
            w_an_act[w_idx_nxt] = 1'b1;
            w_seg_act           = w_snap_lz ? c_seg_off : w_seg_hi;
            w_dp_act            = w_snap_dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_scan_q <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= 8'd0;
            r_nib    <= 4'h0;
            r_dp     <= 1'b0;
            r_lz     <= 1'b0;
            an       <= c_an_off;
            seg      <= c_seg_pin_off;
            dp_o     <= c_dp_pin_off;
        end else begin
            r_state  <= w_state_nxt;
            r_scan_q <= scan_clk;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_nib    <= w_snap_nib;
            r_dp     <= w_snap_dp;
            r_lz     <= w_snap_lz;
            an       <= w_an_act ^ c_an_off;
            seg      <= w_seg_act ^ c_seg_pin_off;
            dp_o     <= w_dp_act ^ c_dp_pin_off;
        end
    end

    assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
//==============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Directed, table-driven bench for seven_seg_scanner.
// Revision : 1.0 - initial release
//==============================================================================
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blank_lz;
    logic [15:0] value;
    logic [3:0]  dp;

    logic        scan_clk;
    logic        scan_clk_f;
    int          div_cnt;
    int          div_cnt_f;

    logic [3:0]  an,   an_f;
    logic [6:0]  seg,  seg_f;
    logic        dp_o, dp_o_f;
    logic [1:0]  digit_idx, digit_idx_f;

    int applied = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    // Clock dividers feeding scan_clk: DIV=5 for the main DUT, DIV=3 for the fast one
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= 0;
            scan_clk   <= 1'b0;
            div_cnt_f  <= 0;
            scan_clk_f <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == 4) ? 0 : div_cnt + 1;
            scan_clk   <= (div_cnt < 2);
            div_cnt_f  <= (div_cnt_f == 2) ? 0 : div_cnt_f + 1;
            scan_clk_f <= (div_cnt_f == 0);
        end
    end

    seven_seg_scanner #(
        .DIGITS(4), .BLANK_CYCLES(2), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .en(en), .value(value), .dp(dp),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp_o(dp_o), .digit_idx(digit_idx)
    );

    seven_seg_scanner #(
        .DIGITS(4), .BLANK_CYCLES(8), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) dut_fast (
        .clk(clk), .rst(rst), .scan_clk(scan_clk_f), .en(en), .value(value), .dp(dp),
        .blank_lz(blank_lz), .an(an_f), .seg(seg_f), .dp_o(dp_o_f), .digit_idx(digit_idx_f)
    );

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}, active-low
        logic [3:0]  dpo;    // expected dp_o per digit, active-low
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Skip the current digit, count the dark gap, then capture the next shown digit
    task automatic next_digit(output logic [3:0] got_an, output logic [6:0] got_seg,
                              output logic got_dp, output logic [1:0] got_idx,
                              output int gap, output int bad_off, output bit tmo);
        int n;
        bit stuck;
        n       = 0;
        gap     = 0;
        bad_off = 0;
        while (an !== 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        stuck = (an !== 4'hF);
        while (an === 4'hF && n < 300) begin
            gap++;
            if (seg !== 7'h7F || dp_o !== 1'b1) bad_off++;
            @(negedge clk);
            n++;
        end
        tmo     = stuck || (an === 4'hF);
        got_an  = an;
        got_seg = seg;
        got_dp  = dp_o;
        got_idx = digit_idx;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, applied %0d", applied);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0] g_an, exp_an;
        logic [6:0] g_seg, exp_seg;
        logic       g_dp;
        logic [1:0] g_idx, held_idx;
        int         gap, bad_off, n, lat, stale_bad, tear_cycles;
        int         rises, changes, step_bad, show_seen;
        logic       prev_scan, prev_idx_valid;
        logic [1:0] prev_idx;
        bit         tmo;

        vecs[0] = '{16'h1234, 4'h0,    1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'h0007, 4'h0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF};
        vecs[2] = '{16'h0007, 4'h0,    1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF};
        vecs[3] = '{16'h5678, 4'b0101, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1010};
        vecs[4] = '{16'h9ABC, 4'h0,    1'b1, {7'h10, 7'h08, 7'h03, 7'h46}, 4'hF};
        vecs[5] = '{16'hDEF0, 4'h0,    1'b1, {7'h21, 7'h06, 7'h0E, 7'h40}, 4'hF};
        vecs[6] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
        vecs[7] = '{16'h0300, 4'h0,    1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'hF};

        rst = 1'b1; en = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an",   32'(an),        32'hF);
        check("reset_seg",  32'(seg),       32'h7F);
        check("reset_dp",   32'(dp_o),      32'h1);
        check("reset_idx",  32'(digit_idx), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_an_off", 32'(an), 32'hF);

        // Table-driven scans: each vector restarts from IDLE so digit 0 comes first
        for (int v = 0; v < 8; v++) begin
            en = 1'b0;
            @(negedge clk);
            value    = vecs[v].value;
            dp       = vecs[v].dp;
            blank_lz = vecs[v].lz;
            @(negedge clk);
            en = 1'b1;
            for (int d = 0; d < 4; d++) begin
                next_digit(g_an, g_seg, g_dp, g_idx, gap, bad_off, tmo);
                exp_an  = ~(4'b0001 << d);
                exp_seg = vecs[v].segs[7*d +: 7];
                check($sformatf("v%0d_d%0d_timeout", v, d), 32'(tmo),     32'h0);
                check($sformatf("v%0d_d%0d_an", v, d),      32'(g_an),    32'(exp_an));
                check($sformatf("v%0d_d%0d_idx", v, d),     32'(g_idx),   32'(d));
                check($sformatf("v%0d_d%0d_seg", v, d),     32'(g_seg),   32'(exp_seg));
                check($sformatf("v%0d_d%0d_dp", v, d),      32'(g_dp),    32'(vecs[v].dpo[d]));
                check($sformatf("v%0d_d%0d_gap_dark", v, d), 32'(bad_off), 32'h0);
                if (d > 0) check($sformatf("v%0d_d%0d_gap", v, d), 32'(gap), 32'd2);
            end
        end

        // Tearing: value changes while digit 2 is on; digit 2 keeps its snapshot
        en = 1'b0; @(negedge clk);
        value = 16'h0000; dp = 4'h0; blank_lz = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int d = 0; d < 3; d++) next_digit(g_an, g_seg, g_dp, g_idx, gap, bad_off, tmo);
        check("tear_d2_an",  32'(g_an),  32'hB);
        check("tear_d2_seg", 32'(g_seg), 32'h40);
        value       = 16'hFFFF;
        stale_bad   = 0;
        tear_cycles = 0;
        @(negedge clk);
        while (an === 4'hB && tear_cycles < 20) begin
            tear_cycles++;
            if (seg !== 7'h40) stale_bad++;
            @(negedge clk);
        end
        check("tear_hold_cycles", 32'(tear_cycles), 32'd2);
        check("tear_hold_seg",    32'(stale_bad),   32'd0);
        next_digit(g_an, g_seg, g_dp, g_idx, gap, bad_off, tmo);
        check("tear_d3_an",  32'(g_an),  32'h7);
        check("tear_d3_seg", 32'(g_seg), 32'h0E);

        // Enable drop mid-digit, then resume latency from the next scan rise
        next_digit(g_an, g_seg, g_dp, g_idx, gap, bad_off, tmo);
        held_idx = g_idx;
        en = 1'b0;
        @(negedge clk);
        check("en_off_an",  32'(an),   32'hF);
        check("en_off_seg", 32'(seg),  32'h7F);
        check("en_off_dp",  32'(dp_o), 32'h1);
        repeat (12) @(negedge clk);
        check("en_off_idx_held", 32'(digit_idx), 32'(held_idx));
        check("en_off_still_off", 32'(an), 32'hF);
        n = 0;
        while (scan_clk !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        en = 1'b1;
        prev_scan = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scan_clk === 1'b1 && prev_scan === 1'b0) break;
            prev_scan = scan_clk;
        end while (n < 20);
        lat = 0;
        while (an === 4'hF && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("resume_latency", 32'(lat),       32'd3);
        check("resume_an",      32'(an),        32'hE);
        check("resume_idx",     32'(digit_idx), 32'h0);
        check("resume_seg",     32'(seg),       32'h0E);

        // Asynchronous reset while a non-zero digit is on
        value = 16'h1234;
        n = 0;
        do begin
            next_digit(g_an, g_seg, g_dp, g_idx, gap, bad_off, tmo);
            n++;
        end while (g_idx !== 2'd2 && n < 8);
        check("pre_rst_idx", 32'(digit_idx), 32'h2);
        #1 rst = 1'b1;
        #1;
        check("async_rst_an",  32'(an),   32'hF);
        check("async_rst_seg", 32'(seg),  32'h7F);
        check("async_rst_dp",  32'(dp_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idx", 32'(digit_idx), 32'h0);

        // Fast scan on the BLANK_CYCLES=8, DIV=3 instance: rises land inside BLANK
        repeat (30) @(negedge clk);
        rises = 0; changes = 0; step_bad = 0; show_seen = 0;
        prev_scan = scan_clk_f;
        prev_idx  = digit_idx_f;
        prev_idx_valid = 1'b1;
        for (int t = 1; t <= 61; t++) begin
            @(negedge clk);
            if (an_f !== 4'hF) show_seen++;
            if (t <= 60 && scan_clk_f === 1'b1 && prev_scan === 1'b0) rises++;
            prev_scan = scan_clk_f;
            if (t >= 2 && prev_idx_valid && digit_idx_f !== prev_idx) begin
                changes++;
                if (digit_idx_f !== prev_idx + 2'd1) step_bad++;
            end
            prev_idx = digit_idx_f;
        end
        check("fast_no_show",    32'(show_seen), 32'd0);
        check("fast_rise_count", 32'(rises),     32'd20);
        check("fast_idx_steps",  32'(changes),   32'(rises));
        check("fast_step_by_one", 32'(step_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
`default_nettype wire
